// File: rtl/mips_io_pkg.sv
// mips_io_pkg: register map and defaults shared by the GPIO port blocks.
package mips_io_pkg;
    localparam logic [2:0] ADDR_DIR      = 3'd0;
    localparam logic [2:0] ADDR_DOUT     = 3'd1;
    localparam logic [2:0] ADDR_PIN      = 3'd2;
    localparam logic [2:0] ADDR_IRQ_EN   = 3'd3;
    localparam logic [2:0] ADDR_IRQ_STAT = 3'd4;
    localparam logic [2:0] ADDR_EDGE_SEL = 3'd5;
    localparam int DEBOUNCE_CYCLES_DEF   = 4;
endpackage

// File: rtl/io_pin_filter.sv
// io_pin_filter: per-pin two-flop synchroniser, debounce counter and edge event.
module io_pin_filter
    import mips_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic pin_i,
    input  logic edge_sel_i,
    output logic stable_o,
    output logic event_o
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    logic sync1_q, sync2_q, stable_q, stable_d, done;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb begin
        done     = (sync2_q != stable_q) && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
        cnt_d    = (sync2_q == stable_q || done) ? '0 : cnt_q + CNT_W'(1);
        stable_d = done ? sync2_q : stable_q;
        // edge_sel 0 flags a new level of 1 (rising), 1 flags a new level of 0
        event_o  = done && (sync2_q != edge_sel_i);
    end
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= pin_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end
    assign stable_o = stable_q;
endmodule

// File: rtl/io_port_ctrl.sv
// io_port_ctrl: memory-mapped GPIO port with direction control, debounced inputs
// and a sticky, maskable edge interrupt.
module io_port_ctrl
    import mips_io_pkg::*;
#(
    parameter int WIDTH           = 32,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             wr,
    input  logic [2:0]       addr,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             irq,
    inout  wire  [WIDTH-1:0] port_io
);
    logic [WIDTH-1:0] dir_q, dout_q, en_q, stat_q, sel_q, stat_d, pin_w, ev_w;
    logic we;
    assign we = ce & wr;
    for (genvar g = 0; g < WIDTH; g++) begin : g_pin
        io_pin_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filt (
            .sys_clk   (sys_clk),
            .rst_n     (rst_n),
            .pin_i     (port_io[g]),
            .edge_sel_i(sel_q[g]),
            .stable_o  (pin_w[g]),
            .event_o   (ev_w[g])
        );
        assign port_io[g] = dir_q[g] ? dout_q[g] : 1'bz;
    end
    // a new event outranks a clear landing on the same edge
    assign stat_d = (stat_q & ~((we && addr == ADDR_IRQ_STAT) ? data_in : '0)) | ev_w;
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q  <= '0;
            dout_q <= '0;
            en_q   <= '0;
            stat_q <= '0;
            sel_q  <= '0;
        end else begin
            if (we && addr == ADDR_DIR)      dir_q  <= data_in;
            if (we && addr == ADDR_DOUT)     dout_q <= data_in;
            if (we && addr == ADDR_IRQ_EN)   en_q   <= data_in;
            if (we && addr == ADDR_EDGE_SEL) sel_q  <= data_in;
            stat_q <= stat_d;
        end
    end
    always_comb begin
        data_out = !(ce && !wr)              ? '0     :
                   (addr == ADDR_DIR)        ? dir_q  :
                   (addr == ADDR_DOUT)       ? dout_q :
                   (addr == ADDR_PIN)        ? pin_w  :
                   (addr == ADDR_IRQ_EN)     ? en_q   :
                   (addr == ADDR_IRQ_STAT)   ? stat_q :
                   (addr == ADDR_EDGE_SEL)   ? sel_q  : '0;
        irq = |(stat_q & en_q);
    end
endmodule

// File: tb/tb_io_port_ctrl.sv
// tb_io_port_ctrl: directed, table-driven checks of the GPIO port register map,
// debounce latency, glitch rejection, interrupts and reset behaviour.
module tb_io_port_ctrl;
    import mips_io_pkg::*;

    logic        sys_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic        ce      = 1'b0;
    logic        wr      = 1'b0;
    logic [2:0]  addr    = '0;
    logic [31:0] data_in = '0;
    logic [31:0] dir_m   = '0;
    logic [31:0] tb_val  = '0;
    wire  [31:0] data_out;
    wire         irq;
    wire  [31:0] port_io;
    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0]  a;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[10];

    always #10 sys_clk = ~sys_clk;

    // the bench drives every pin the DUT is not configured to drive
    for (genvar i = 0; i < 32; i++) begin : g_drv
        assign port_io[i] = dir_m[i] ? 1'bz : tb_val[i];
    end

    io_port_ctrl dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .ce      (ce),
        .wr      (wr),
        .addr    (addr),
        .data_in (data_in),
        .data_out(data_out),
        .irq     (irq),
        .port_io (port_io)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
        ce = 1'b1; wr = 1'b1; addr = a; data_in = d;
        tick(1);
        ce = 1'b0; wr = 1'b0; data_in = '0;
    endtask

    task automatic rd_chk(input string nm, input logic [2:0] a, input logic [31:0] exp);
        ce = 1'b1; wr = 1'b0; addr = a;
        #1;
        chk(nm, data_out, exp);
        ce = 1'b0;
    endtask

    task automatic irq_chk(input string nm, input logic exp);
        chk(nm, {31'b0, irq}, {31'b0, exp});
    endtask

    initial begin
        tbl[0] = '{ADDR_IRQ_EN,   32'hDEAD_BEEF, 32'hDEAD_BEEF};
        tbl[1] = '{ADDR_EDGE_SEL, 32'h1234_5678, 32'h1234_5678};
        tbl[2] = '{ADDR_DOUT,     32'hCAFE_F00D, 32'hCAFE_F00D};
        tbl[3] = '{ADDR_PIN,      32'hFFFF_FFFF, 32'h0};
        tbl[4] = '{ADDR_IRQ_STAT, 32'hFFFF_FFFF, 32'h0};
        tbl[5] = '{3'd6,          32'hFFFF_FFFF, 32'h0};
        tbl[6] = '{3'd7,          32'hA5A5_A5A5, 32'h0};
        tbl[7] = '{ADDR_IRQ_EN,   32'h0,         32'h0};
        tbl[8] = '{ADDR_EDGE_SEL, 32'h0,         32'h0};
        tbl[9] = '{ADDR_DOUT,     32'h0,         32'h0};

        // reset state
        #5;
        irq_chk("rst_irq", 1'b0);
        for (int a = 0; a < 8; a++) rd_chk($sformatf("rst_reg%0d", a), 3'(a), 32'h0);
        #45;
        rst_n = 1'b1;
        tick(1);

        // register map
        for (int k = 0; k < 10; k++) begin
            wr_reg(tbl[k].a, tbl[k].wd);
            rd_chk($sformatf("tbl%0d", k), tbl[k].a, tbl[k].exp);
            irq_chk($sformatf("tbl%0d_irq", k), 1'b0);
        end

        // debounced press: visible exactly 6 edges after the first sample
        wr_reg(ADDR_IRQ_EN, 32'h8);
        tb_val[3] = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            rd_chk($sformatf("t2_pin_e%0d", k), ADDR_PIN, (k == 6) ? 32'h8 : 32'h0);
            irq_chk($sformatf("t2_irq_e%0d", k), k == 6);
        end
        rd_chk("t2_stat", ADDR_IRQ_STAT, 32'h8);
        wr_reg(ADDR_IRQ_STAT, 32'h8);
        irq_chk("t2_irq_clr", 1'b0);
        tb_val[3] = 1'b0;
        tick(8);
        rd_chk("t2_rel_pin", ADDR_PIN, 32'h0);
        rd_chk("t2_rel_stat", ADDR_IRQ_STAT, 32'h0);
        wr_reg(ADDR_IRQ_EN, 32'h0);

        // glitch rejection: 3 cycles dropped, 4 cycles accepted
        tb_val[0] = 1'b1;
        tick(3);
        tb_val[0] = 1'b0;
        tick(8);
        rd_chk("t3_glitch_pin", ADDR_PIN, 32'h0);
        rd_chk("t3_glitch_stat", ADDR_IRQ_STAT, 32'h0);
        tb_val[0] = 1'b1;
        tick(4);
        tb_val[0] = 1'b0;
        tick(2);
        rd_chk("t3_four_pin", ADDR_PIN, 32'h1);
        rd_chk("t3_four_stat", ADDR_IRQ_STAT, 32'h1);
        tick(8);
        rd_chk("t3_four_rel_pin", ADDR_PIN, 32'h0);
        rd_chk("t3_four_rel_stat", ADDR_IRQ_STAT, 32'h1);
        wr_reg(ADDR_IRQ_STAT, 32'h1);

        // falling-edge select with masked interrupt
        wr_reg(ADDR_EDGE_SEL, 32'h2);
        tb_val[1] = 1'b1;
        tick(8);
        rd_chk("t4_press_pin", ADDR_PIN, 32'h2);
        rd_chk("t4_press_stat", ADDR_IRQ_STAT, 32'h0);
        tb_val[1] = 1'b0;
        tick(8);
        rd_chk("t4_rel_stat", ADDR_IRQ_STAT, 32'h2);
        irq_chk("t4_masked_irq", 1'b0);
        wr_reg(ADDR_IRQ_EN, 32'h2);
        irq_chk("t4_unmask_irq", 1'b1);
        wr_reg(ADDR_IRQ_STAT, 32'h2);
        irq_chk("t4_clr_irq", 1'b0);
        wr_reg(ADDR_EDGE_SEL, 32'h0);
        wr_reg(ADDR_IRQ_EN, 32'h0);

        // output drive and readback
        wr_reg(ADDR_DOUT, 32'hFFFF_FFA0);
        dir_m = 32'h0000_00F0;
        wr_reg(ADDR_DIR, 32'h0000_00F0);
        chk("t5_pins", port_io, 32'h0000_00A0);
        rd_chk("t5_dir", ADDR_DIR, 32'h0000_00F0);
        ce = 1'b0; addr = ADDR_DIR;
        #1;
        chk("t5_ce0_out", data_out, 32'h0);
        ce = 1'b1; wr = 1'b1; data_in = 32'h0000_00F0;
        #1;
        chk("t5_wr_out", data_out, 32'h0);
        ce = 1'b0; wr = 1'b0; data_in = '0;
        tick(5);
        rd_chk("t5_pin_e5", ADDR_PIN, 32'h0);
        tick(1);
        rd_chk("t5_pin_e6", ADDR_PIN, 32'h0000_00A0);
        rd_chk("t5_stat", ADDR_IRQ_STAT, 32'h0000_00A0);
        wr_reg(ADDR_DIR, 32'h0);
        dir_m = '0;
        tick(8);
        rd_chk("t5_rel_pin", ADDR_PIN, 32'h0);
        wr_reg(ADDR_IRQ_STAT, 32'hFFFF_FFFF);
        rd_chk("t5_rel_stat", ADDR_IRQ_STAT, 32'h0);

        // set/clear collision on the event edge, then a plain clear
        tb_val[2] = 1'b1;
        tick(5);
        rd_chk("t6_pre_stat", ADDR_IRQ_STAT, 32'h0);
        wr_reg(ADDR_IRQ_STAT, 32'h4);
        rd_chk("t6_collide_stat", ADDR_IRQ_STAT, 32'h4);
        wr_reg(ADDR_IRQ_STAT, 32'h4);
        rd_chk("t6_clear_stat", ADDR_IRQ_STAT, 32'h0);
        rd_chk("t6_addr6", 3'd6, 32'h0);
        rd_chk("t6_addr7", 3'd7, 32'h0);

        // async reset mid-debounce, then rising events for pins already high
        wr_reg(ADDR_IRQ_EN, 32'h6);
        tb_val[1] = 1'b1;
        tick(4);
        rd_chk("t7_pre_pin", ADDR_PIN, 32'h4);
        rst_n = 1'b0;
        rd_chk("t7_rst_pin", ADDR_PIN, 32'h0);
        rd_chk("t7_rst_en", ADDR_IRQ_EN, 32'h0);
        tick(2);
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick(1);
            rd_chk($sformatf("t7_pin_e%0d", k), ADDR_PIN, (k == 6) ? 32'h6 : 32'h0);
        end
        rd_chk("t7_stat", ADDR_IRQ_STAT, 32'h6);
        irq_chk("t7_irq", 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
